iss_issue_arbiter: RTL and testbench

//  Weighted round-robin arbiter sharing the single execute issue port between the IQ and the LSQ.

---
 rtl/iss_issue_arbiter.sv | 92 +++++++++
 tb/tb_iss_issue_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iss_issue_arbiter.sv
// Weighted round-robin arbiter sharing the execute issue port between IQ and LSQ,
// feeding a one-deep issue register with a valid/ready handshake to EXE.
module iss_issue_arbiter #(
  parameter int unsigned DATA_WIDTH = 137,
  parameter int unsigned IQ_WEIGHT  = 2,
  parameter int unsigned CNT_BITS   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FREEZE,
  input  logic                  FLUSH_IN,
  input  logic                  IQ_req_IN,
  input  logic [DATA_WIDTH-1:0] IQ_data_IN,
  input  logic                  LSQ_req_IN,
  input  logic [DATA_WIDTH-1:0] LSQ_data_IN,
  input  logic                  EXE_ready_IN,
  output logic                  IQ_grant_OUT,
  output logic                  LSQ_grant_OUT,
  output logic                  ISS_valid_OUT,
  output logic [DATA_WIDTH-1:0] ISS_data_OUT,
  output logic                  IQSelected_OUT
);

  typedef enum logic [0:0] {PrefIq, PrefLsq} pref_e;

  // Last contested IQ win before the preference hands over to LSQ.
  localparam logic [CNT_BITS-1:0] LastIqWin = CNT_BITS'(IQ_WEIGHT - 1);

  pref_e                 pref;
  logic [CNT_BITS-1:0]   winCnt;
  logic                  issValid;
  logic [DATA_WIDTH-1:0] issData;
  logic                  iqSel;

  logic slotFree;
  logic gntEn;
  logic contested;
  logic iqGrant;
  logic lsqGrant;

  always_comb begin
    slotFree  = !issValid || EXE_ready_IN;
    gntEn     = slotFree && !FREEZE && !FLUSH_IN && RESET;
    contested = gntEn && IQ_req_IN && LSQ_req_IN;
    iqGrant   = gntEn && IQ_req_IN && (!LSQ_req_IN || (pref == PrefIq));
    lsqGrant  = gntEn && LSQ_req_IN && (!IQ_req_IN || (pref == PrefLsq));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      issValid <= 1'b0;
      issData  <= '0;
      iqSel    <= 1'b0;
      pref     <= PrefIq;
      winCnt   <= '0;
    end else if (FLUSH_IN) begin
      issValid <= 1'b0;
    end else if (!FREEZE) begin
      if (iqGrant || lsqGrant) begin
        issValid <= 1'b1;
        issData  <= iqGrant ? IQ_data_IN : LSQ_data_IN;
        iqSel    <= iqGrant;
      end else if (slotFree) begin
        issValid <= 1'b0;
      end

      // Only contested grants move the weighting state.
      if (contested) begin
        if (pref == PrefIq) begin
          if (winCnt == LastIqWin) begin
            pref   <= PrefLsq;
            winCnt <= '0;
          end else begin
            winCnt <= winCnt + CNT_BITS'(1);
          end
        end else begin
          pref   <= PrefIq;
          winCnt <= '0;
        end
      end
    end
  end

  always_comb begin
    IQ_grant_OUT   = iqGrant;
    LSQ_grant_OUT  = lsqGrant;
    ISS_valid_OUT  = issValid;
    ISS_data_OUT   = issData;
    IQSelected_OUT = iqSel;
  end

endmodule

// File: tb/tb_iss_issue_arbiter.sv
// Self-checking bench for iss_issue_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the weighted arbitration.
module tb_iss_issue_arbiter;

  localparam int DW  = 137;
  localparam int IQW = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          FREEZE = 1'b0;
  logic          FLUSH_IN = 1'b0;
  logic          IQ_req_IN = 1'b0;
  logic [DW-1:0] IQ_data_IN = '0;
  logic          LSQ_req_IN = 1'b0;
  logic [DW-1:0] LSQ_data_IN = '0;
  logic          EXE_ready_IN = 1'b0;
  logic          IQ_grant_OUT;
  logic          LSQ_grant_OUT;
  logic          ISS_valid_OUT;
  logic [DW-1:0] ISS_data_OUT;
  logic          IQSelected_OUT;

  iss_issue_arbiter #(
    .DATA_WIDTH(DW),
    .IQ_WEIGHT (IQW),
    .CNT_BITS  (2)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .FREEZE        (FREEZE),
    .FLUSH_IN      (FLUSH_IN),
    .IQ_req_IN     (IQ_req_IN),
    .IQ_data_IN    (IQ_data_IN),
    .LSQ_req_IN    (LSQ_req_IN),
    .LSQ_data_IN   (LSQ_data_IN),
    .EXE_ready_IN  (EXE_ready_IN),
    .IQ_grant_OUT  (IQ_grant_OUT),
    .LSQ_grant_OUT (LSQ_grant_OUT),
    .ISS_valid_OUT (ISS_valid_OUT),
    .ISS_data_OUT  (ISS_data_OUT),
    .IQSelected_OUT(IQSelected_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: mWins counts consecutive contested IQ wins; IQ_WEIGHT of them hands one to LSQ.
  int            mWins = 0;
  bit            mValid = 1'b0;
  logic [DW-1:0] mData = '0;
  bit            mSel = 1'b0;
  bit            eIq, eLsq;
  bit            gIq, gLsq;

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void predict();
    bit en;
    en   = (!mValid || EXE_ready_IN) && !FREEZE && !FLUSH_IN && RESET;
    eIq  = en && IQ_req_IN && (!LSQ_req_IN || (mWins < IQW));
    eLsq = en && LSQ_req_IN && !eIq;
  endfunction

  function automatic void modelReset();
    mValid = 1'b0;
    mData  = '0;
    mSel   = 1'b0;
    mWins  = 0;
  endfunction

  function automatic void update();
    if (!RESET) begin
      modelReset();
    end else if (FLUSH_IN) begin
      mValid = 1'b0;
    end else if (!FREEZE) begin
      if (eIq || eLsq) begin
        mValid = 1'b1;
        mData  = eIq ? IQ_data_IN : LSQ_data_IN;
        mSel   = eIq;
        if (IQ_req_IN && LSQ_req_IN) mWins = eIq ? mWins + 1 : 0;
      end else if (EXE_ready_IN) begin
        mValid = 1'b0;
      end
    end
  endfunction

  // Inputs are driven just after a negedge; grants checked before the posedge, registers after.
  task automatic step();
    #1;
    predict();
    gIq  = IQ_grant_OUT;
    gLsq = LSQ_grant_OUT;
    checkVal("iqGrant", DW'(IQ_grant_OUT), DW'(eIq));
    checkVal("lsqGrant", DW'(LSQ_grant_OUT), DW'(eLsq));
    @(posedge CLK);
    update();
    #1;
    checkVal("issValid", DW'(ISS_valid_OUT), DW'(mValid));
    checkVal("issData", ISS_data_OUT, mData);
    checkVal("iqSelected", DW'(IQSelected_OUT), DW'(mSel));
    @(negedge CLK);
  endtask

  task automatic drive(input bit iq, input bit lsq, input bit rdy);
    IQ_req_IN    = iq;
    LSQ_req_IN   = lsq;
    EXE_ready_IN = rdy;
    IQ_data_IN   = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    LSQ_data_IN  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic doReset();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  initial begin
    bit [5:0] pat;
    int lsqCount;
    pat = 6'b011011;  // bit i = 1 means IQ wins contested grant i
    @(negedge CLK);

    // Reset held with both requesting, then release.
    drive(1, 1, 1);
    step();
    checkVal("rstGrant", DW'(gIq | gLsq), DW'(0));
    step();
    checkVal("rstValid", DW'(ISS_valid_OUT), DW'(0));
    RESET = 1'b1;
    step();
    checkVal("rstRelease", DW'(gIq), DW'(1));

    // Contested weighted sequence.
    doReset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1);
      step();
      checkVal($sformatf("order%0d", i), DW'(gIq), DW'(pat[i]));
      checkVal($sformatf("selOrder%0d", i), DW'(IQSelected_OUT), DW'(pat[i]));
    end

    // Backpressure holds the issued entry.
    drive(1, 1, 1);
    IQ_data_IN = DW'(12'h1A5);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0);
      step();
      checkVal("bpNoGrant", DW'(gIq | gLsq), DW'(0));
      checkVal("bpData", ISS_data_OUT, DW'(12'h1A5));
    end
    drive(1, 1, 1);
    step();
    checkVal("bpRelease", DW'(gIq | gLsq), DW'(1));

    // Uncontested LSQ traffic leaves the weighting untouched.
    doReset();
    lsqCount = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1);
      step();
      lsqCount += int'(gLsq);
    end
    checkVal("lsqOnly", DW'(lsqCount), DW'(4));
    drive(1, 1, 1);
    step();
    checkVal("afterLsqOnly", DW'(gIq), DW'(1));

    // Freeze mid-stream: one IQ win already counted, so IQ then LSQ once released.
    FREEZE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1);
      step();
      checkVal("frzNoGrant", DW'(gIq | gLsq), DW'(0));
      checkVal("frzValid", DW'(ISS_valid_OUT), DW'(1));
    end
    FREEZE = 1'b0;
    drive(1, 1, 1);
    step();
    checkVal("frzResumeIq", DW'(gIq), DW'(1));
    drive(1, 1, 1);
    step();
    checkVal("frzResumeLsq", DW'(gLsq), DW'(1));

    // Flush pulse squashes the issue register.
    FLUSH_IN = 1'b1;
    drive(1, 1, 1);
    step();
    checkVal("flushNoGrant", DW'(gIq | gLsq), DW'(0));
    checkVal("flushValid", DW'(ISS_valid_OUT), DW'(0));
    FLUSH_IN = 1'b0;

    // Asynchronous reset mid-cycle.
    drive(1, 1, 0);
    step();
    checkVal("preAsyncValid", DW'(ISS_valid_OUT), DW'(1));
    #2;
    RESET = 1'b0;
    #1;
    modelReset();
    checkVal("asyncValid", DW'(ISS_valid_OUT), DW'(0));
    @(negedge CLK);
    step();
    RESET = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0));
      FREEZE   = ($urandom_range(0, 9) == 0);
      FLUSH_IN = ($urandom_range(0, 19) == 0);
      RESET    = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
